// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data (D) requesters,
// with one outstanding read of fixed latency. Optional macro ARB_ROUND_ROBIN_EN enables tie rotation.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  generate
    if (MEM_LAT < 1) begin : g_lat_chk
      $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;  // 1 = D port owns the in-flight read
  logic             d_win;
  logic             idle_grant;
  logic             grant_rd;

  // Outputs are gated by rstn_i so that everything reads 0 while reset is held.
  assign idle_grant = (state_q == IDLE) && rstn_i && (if_req_i || d_req_i);
  assign grant_rd   = idle_grant && !(d_win && d_we_i);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // On a tie the port that was not granted last wins.
  assign d_win        = d_req_i && (!if_req_i || !last_owner_q);
  assign last_owner_d = idle_grant ? d_win : last_owner_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign d_win = d_req_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (grant_rd) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          owner_d = d_win;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    if_rdata_o  = '0;
    d_rdata_o   = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    busy_o      = rstn_i && (state_q == RD_WAIT);
    if (idle_grant) begin
      if (d_win) begin
        d_gnt_o     = 1'b1;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
        mem_we_o    = d_we_i;
        mem_re_o    = !d_we_i;
      end else begin
        if_gnt_o    = 1'b1;
        mem_addr_o  = if_addr_i;
        mem_re_o    = 1'b1;
      end
    end else if (rstn_i && (state_q == RD_WAIT) && (cnt_q == '0)) begin
      if (owner_q) begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = mem_rdata_i;
      end else begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end
    end
  end

endmodule
